global_ldst_req_sync: RTL and testbench
=======================================

// Module: global_ldst_req_sync
// PURPOSE
//  Request-channel synchronizer/scheduler in front of the global load-store unit. One instance serves AR, one serves AW.
//  Waits until every cluster presents its request and merges them into one system request.
//  Rescales the burst to the system bus width.
//  Limits in-flight system bursts and flags cluster skew or disagreement.
// PARAMETERS
//  NrClusters      4    number of Ara clusters (power of 2, >=2)
//  AddrWidth       64   AXI address width
//  IdWidth         5    AXI ID width
//  SysSize         5    log2 of system data bytes per beat (AxiDataWidth/8)
//  MaxOutstanding  4    max issued-but-incomplete system bursts (>=1)
//  SkewTimeout     64   cycles of partial cluster arrival before skew error
// PORTS
//  clk_i           in   1                   clock
//  rst_ni          in   1                   asynchronous reset, active-low
//  cl_valid_i      in   NrClusters          per-cluster request valid
//  cl_ready_o      out  NrClusters          per-cluster request ready
//  cl_addr_i       in   NrClusters*AddrW    per-cluster address
//  cl_len_i        in   NrClusters*8        per-cluster AXI len
//  cl_size_i       in   NrClusters*3        per-cluster AXI size
//  cl_id_i         in   NrClusters*IdW      per-cluster ID
//  sys_valid_o     out  1                   merged request valid
//  sys_ready_i     in   1                   system accepts request
//  sys_addr_o      out  AddrWidth           merged address (cluster 0)
//  sys_len_o       out  8                   rescaled len
//  sys_size_o      out  3                   always SysSize
//  sys_id_o        out  IdWidth             merged ID (cluster 0)
//  done_i          in   1                   burst completion pulse (R last or B handshake)
//  outstanding_o   out  $clog2(MaxOut+1)    in-flight burst count
//  mismatch_err_o  out  1                   sticky: cluster len/size/id disagreement
//  skew_err_o      out  1                   sticky: partial-arrival timeout
//  len_ovf_err_o   out  1                   sticky: rescaled burst > 256 beats
// BEHAVIOUR
//  Reset: state IDLE.
//   cl_ready_o=0, sys_valid_o=0, sys_* regs=0, outstanding_o=0, all err flags=0, skew counter=0.
//  FSM IDLE:
//   - capture when &cl_valid_i && outstanding_o<MaxOutstanding.
//   - cl_ready_o=all-ones in that same cycle (combinational from IDLE and the capture condition).
//   - register cluster-0 fields; cnt+1; next state ISSUE.
//  FSM ISSUE:
//   - sys_valid_o=1, sys_* held stable, cl_ready_o=0.
//   - on sys_ready_i go to IDLE; next capture is possible one cycle later at the earliest.
//  Latency: all-valid capture cycle N -> sys_valid_o at N+1. Max throughput is 1 burst per 2 cycles.
//  Len rescale: beats=((len0+1)<<size0<<log2(NrClusters))>>SysSize, computed 20 bits wide.
//   - beats==0 -> sys_len_o=0.
//   - beats>256 -> sys_len_o=255 and len_ovf_err_o set.
//   - otherwise sys_len_o=beats-1.
//  Mismatch: at capture, any cluster len/size/id != cluster 0 sets mismatch_err_o; the request is still issued.
//  Skew counter: increments each IDLE cycle where some, but not all, cl_valid_i are high; clears otherwise.
//   - at SkewTimeout it sets skew_err_o and saturates.
//  Outstanding:
//   - capture and done_i in the same cycle -> unchanged.
//   - done_i at 0 -> stays 0 (ignored).
//   - at MaxOutstanding, capture is blocked until done_i.
//  Error flags are cleared only by reset. Async reset mid-ISSUE drops sys_valid_o immediately.
// TESTING
//  1. N=4,SysSize=5: all valid, len=3,size=3 -> cl_ready 4'hF in cycle 0; sys_valid cycle 1, sys_len=3.
//  2. Clusters 0-2 valid, cluster 3 valid 10 cycles later -> no issue until cluster 3 arrives; skew_err_o stays 0.
//  3. SkewTimeout=64, cluster 3 never valid -> skew_err_o=1 at cycle 64; sys_valid_o stays 0.
//  4. MaxOut=2: three back-to-back requests, no done_i -> third blocked.
//     done_i pulse -> third issues; outstanding_o sequence 1,2,1,2.
//  5. Cluster 2 len=7 vs others len=3 -> mismatch_err_o=1 and sys_len computed from cluster 0.
//  6. sys_ready_i low 5 cycles in ISSUE -> sys_* stable.
//     Reset asserted mid-ISSUE -> all outputs 0.

Source files
------------

// File: rtl/global_ldst_req_sync.sv
// Request-channel synchronizer for the global load-store unit: merges the per-cluster
// AR or AW requests into one system burst and bounds the number of bursts in flight.

module global_ldst_req_sync_lane #(
  parameter int unsigned IdWidth = 5
) (
  input  logic [7:0]         len_i,
  input  logic [7:0]         ref_len_i,
  input  logic [2:0]         size_i,
  input  logic [2:0]         ref_size_i,
  input  logic [IdWidth-1:0] id_i,
  input  logic [IdWidth-1:0] ref_id_i,
  output logic               mismatch_o
);
  assign mismatch_o = (len_i != ref_len_i) || (size_i != ref_size_i) || (id_i != ref_id_i);
endmodule

module global_ldst_req_sync #(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned SysSize        = 5,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned SkewTimeout    = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NrClusters-1:0]                  cl_valid_i,
  output logic [NrClusters-1:0]                  cl_ready_o,
  input  logic [NrClusters-1:0][AddrWidth-1:0]   cl_addr_i,
  input  logic [NrClusters-1:0][7:0]             cl_len_i,
  input  logic [NrClusters-1:0][2:0]             cl_size_i,
  input  logic [NrClusters-1:0][IdWidth-1:0]     cl_id_i,
  output logic                                   sys_valid_o,
  input  logic                                   sys_ready_i,
  output logic [AddrWidth-1:0]                   sys_addr_o,
  output logic [7:0]                             sys_len_o,
  output logic [2:0]                             sys_size_o,
  output logic [IdWidth-1:0]                     sys_id_o,
  input  logic                                   done_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
  output logic                                   mismatch_err_o,
  output logic                                   skew_err_o,
  output logic                                   len_ovf_err_o
);
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned SkewW = $clog2(SkewTimeout + 1);
  localparam int unsigned LogN  = $clog2(NrClusters);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   sys_addr_q, sys_addr_d;
  logic [7:0]             sys_len_q, sys_len_d;
  logic [2:0]             sys_size_q, sys_size_d;
  logic [IdWidth-1:0]     sys_id_q, sys_id_d;
  logic [OutW-1:0]        out_q, out_d;
  logic [SkewW-1:0]       skew_cnt_q, skew_cnt_d;
  logic                   mis_err_q, mis_err_d;
  logic                   skew_err_q, skew_err_d;
  logic                   ovf_err_q, ovf_err_d;

  logic                   all_valid, partial, capture, dec;
  logic [NrClusters-1:0]  lane_mis;
  logic [19:0]            len_plus1, beats;
  logic [7:0]             len_scaled;
  logic                   unused_addr;

  // Only cluster 0's address is forwarded; the others merely have to be present.
  assign unused_addr = ^cl_addr_i[NrClusters-1:1];

  for (genvar g = 0; g < NrClusters; g++) begin : g_lane
    global_ldst_req_sync_lane #(.IdWidth(IdWidth)) u_lane (
      .len_i      (cl_len_i[g]),
      .ref_len_i  (cl_len_i[0]),
      .size_i     (cl_size_i[g]),
      .ref_size_i (cl_size_i[0]),
      .id_i       (cl_id_i[g]),
      .ref_id_i   (cl_id_i[0]),
      .mismatch_o (lane_mis[g])
    );
  end

  assign all_valid = &cl_valid_i;
  assign partial   = (state_q == IDLE) && (|cl_valid_i) && !all_valid;
  assign capture   = (state_q == IDLE) && all_valid && (out_q < OutW'(MaxOutstanding));
  assign dec       = done_i && (out_q != '0);

  // Total bytes of all clusters' bursts, re-expressed in system-width beats.
  assign len_plus1 = {12'd0, cl_len_i[0]} + 20'd1;
  assign beats     = ((len_plus1 << cl_size_i[0]) << LogN) >> SysSize;

  always_comb begin
    len_scaled = 8'(beats - 20'd1);
    if (beats == 20'd0)        len_scaled = 8'd0;
    else if (beats > 20'd256)  len_scaled = 8'd255;
  end

  always_comb begin
    state_d    = state_q;
    cl_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          cl_ready_o = '1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (sys_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sys_addr_d = sys_addr_q;
    sys_len_d  = sys_len_q;
    sys_size_d = sys_size_q;
    sys_id_d   = sys_id_q;
    mis_err_d  = mis_err_q;
    ovf_err_d  = ovf_err_q;
    if (capture) begin
      sys_addr_d = cl_addr_i[0];
      sys_len_d  = len_scaled;
      sys_size_d = 3'(SysSize);
      sys_id_d   = cl_id_i[0];
      mis_err_d  = mis_err_q | (|lane_mis);
      ovf_err_d  = ovf_err_q | (beats > 20'd256);
    end
  end

  // A completion with nothing in flight is ignored rather than cancelling a capture.
  always_comb begin
    out_d = out_q;
    if (capture && !dec)      out_d = out_q + OutW'(1);
    else if (!capture && dec) out_d = out_q - OutW'(1);
  end

  always_comb begin
    skew_cnt_d = '0;
    skew_err_d = skew_err_q;
    if (partial) begin
      skew_cnt_d = skew_cnt_q;
      if (skew_cnt_q != SkewW'(SkewTimeout)) skew_cnt_d = skew_cnt_q + SkewW'(1);
      if (skew_cnt_d == SkewW'(SkewTimeout)) skew_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sys_addr_q <= '0;
      sys_len_q  <= '0;
      sys_size_q <= '0;
      sys_id_q   <= '0;
      out_q      <= '0;
      skew_cnt_q <= '0;
      mis_err_q  <= 1'b0;
      skew_err_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sys_addr_q <= sys_addr_d;
      sys_len_q  <= sys_len_d;
      sys_size_q <= sys_size_d;
      sys_id_q   <= sys_id_d;
      out_q      <= out_d;
      skew_cnt_q <= skew_cnt_d;
      mis_err_q  <= mis_err_d;
      skew_err_q <= skew_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign sys_valid_o    = (state_q == ISSUE);
  assign sys_addr_o     = sys_addr_q;
  assign sys_len_o      = sys_len_q;
  assign sys_size_o     = sys_size_q;
  assign sys_id_o       = sys_id_q;
  assign outstanding_o  = out_q;
  assign mismatch_err_o = mis_err_q;
  assign skew_err_o     = skew_err_q;
  assign len_ovf_err_o  = ovf_err_q;

endmodule

// File: tb/tb_global_ldst_req_sync.sv
// Bench for global_ldst_req_sync: cycle model checked every negedge plus directed literal checks.

module tb_global_ldst_req_sync;
  localparam int N    = 4;
  localparam int AW   = 64;
  localparam int IW   = 5;
  localparam int SS   = 5;
  localparam int MAXO = 2;
  localparam int SKEW = 64;
  localparam int OW   = $clog2(MAXO + 1);

  logic                   clk, rst_ni;
  logic [N-1:0]           cl_valid, cl_ready;
  logic [N-1:0][AW-1:0]   cl_addr;
  logic [N-1:0][7:0]      cl_len;
  logic [N-1:0][2:0]      cl_size;
  logic [N-1:0][IW-1:0]   cl_id;
  logic                   sys_valid, sys_ready;
  logic [AW-1:0]          sys_addr;
  logic [7:0]             sys_len;
  logic [2:0]             sys_size;
  logic [IW-1:0]          sys_id;
  logic                   done;
  logic [OW-1:0]          outstanding;
  logic                   mis_err, skew_err, ovf_err;

  global_ldst_req_sync #(
    .NrClusters(N), .AddrWidth(AW), .IdWidth(IW), .SysSize(SS),
    .MaxOutstanding(MAXO), .SkewTimeout(SKEW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cl_valid_i(cl_valid), .cl_ready_o(cl_ready),
    .cl_addr_i(cl_addr), .cl_len_i(cl_len), .cl_size_i(cl_size), .cl_id_i(cl_id),
    .sys_valid_o(sys_valid), .sys_ready_i(sys_ready),
    .sys_addr_o(sys_addr), .sys_len_o(sys_len), .sys_size_o(sys_size), .sys_id_o(sys_id),
    .done_i(done), .outstanding_o(outstanding),
    .mismatch_err_o(mis_err), .skew_err_o(skew_err), .len_ovf_err_o(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Total cluster bytes divided by the system beat size, in plain integer arithmetic.
  function automatic int total_beats(input int len, input int size);
    return ((len + 1) * (1 << size) * N) / (1 << SS);
  endfunction

  function automatic int scaled_len(input int len, input int size);
    int b;
    b = total_beats(len, size);
    if (b == 0) return 0;
    if (b > 256) return 255;
    return b - 1;
  endfunction

  // Reference state: is a merged request pending, what it carries, and the counters.
  bit          m_busy = 0;
  logic [63:0] m_addr = '0;
  int          m_len = 0, m_size = 0, m_id = 0;
  int          m_out = 0, m_skew = 0;
  bit          m_mis = 0, m_skw = 0, m_ovf = 0;

  always @(negedge clk) begin
    bit all_v, cap, part;
    if (!rst_ni) begin
      m_busy = 0; m_addr = '0; m_len = 0; m_size = 0; m_id = 0;
      m_out = 0; m_skew = 0; m_mis = 0; m_skw = 0; m_ovf = 0;
    end
    all_v = (cl_valid == {N{1'b1}});
    cap   = rst_ni && !m_busy && all_v && (m_out < MAXO);
    part  = !m_busy && (cl_valid != '0) && !all_v;

    chk("m_cl_ready", 64'(cl_ready), cap ? 64'((1 << N) - 1) : 64'd0);
    chk("m_sys_valid", 64'(sys_valid), 64'(m_busy));
    chk("m_outstanding", 64'(outstanding), 64'(m_out));
    chk("m_mismatch_err", 64'(mis_err), 64'(m_mis));
    chk("m_skew_err", 64'(skew_err), 64'(m_skw));
    chk("m_len_ovf_err", 64'(ovf_err), 64'(m_ovf));
    if (m_busy) begin
      chk("m_sys_addr", 64'(sys_addr), m_addr);
      chk("m_sys_len", 64'(sys_len), 64'(m_len));
      chk("m_sys_size", 64'(sys_size), 64'(m_size));
      chk("m_sys_id", 64'(sys_id), 64'(m_id));
    end

    if (rst_ni) begin
      if (part) begin
        if (m_skew < SKEW) m_skew++;
        if (m_skew == SKEW) m_skw = 1;
      end else m_skew = 0;
      m_out = m_out + int'(cap) - int'(done && m_out > 0);
      if (cap) begin
        m_busy = 1;
        m_addr = cl_addr[0];
        m_len  = scaled_len(int'(cl_len[0]), int'(cl_size[0]));
        m_size = SS;
        m_id   = int'(cl_id[0]);
        for (int k = 1; k < N; k++)
          if (cl_len[k] != cl_len[0] || cl_size[k] != cl_size[0] || cl_id[k] != cl_id[0]) m_mis = 1;
        if (total_beats(int'(cl_len[0]), int'(cl_size[0])) > 256) m_ovf = 1;
      end else if (m_busy && sys_ready) m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [63:0] addr, input int len,
                       input int size, input int id);
    cl_valid = v;
    for (int k = 0; k < N; k++) begin
      cl_addr[k] = addr + 64'(k * 'h100);
      cl_len[k]  = 8'(len);
      cl_size[k] = 3'(size);
      cl_id[k]   = IW'(id);
    end
  endtask

  // One full request: capture, one ISSUE cycle accepted, then its completion.
  task automatic issue(input logic [63:0] addr, input int len, input int size, input int id,
                       input int len2, input int exp_len, input string tag);
    tick();
    drive('1, addr, len, size, id);
    cl_len[2] = 8'(len2);
    sys_ready = 1'b0;
    #1 chk({tag, "_cl_ready"}, 64'(cl_ready), 64'hF);
    tick();
    cl_valid  = '0;
    sys_ready = 1'b1;
    #1;
    chk({tag, "_sys_valid"}, 64'(sys_valid), 64'd1);
    chk({tag, "_sys_len"}, 64'(sys_len), 64'(exp_len));
    chk({tag, "_sys_addr"}, 64'(sys_addr), addr);
    chk({tag, "_sys_size"}, 64'(sys_size), 64'd5);
    chk({tag, "_outst"}, 64'(outstanding), 64'd1);
    tick();
    sys_ready = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; sys_ready = 1'b0; done = 1'b0;
    drive('0, 64'd0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_sys_valid", 64'(sys_valid), 64'd0);
    chk("rst_cl_ready", 64'(cl_ready), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    chk("rst_sys_size", 64'(sys_size), 64'd0);
    chk("rst_errs", 64'({mis_err, skew_err, ovf_err}), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Basic merge: 4 clusters x 4 beats x 8 B = 128 B = 4 system beats.
    issue(64'h1000, 3, 3, 5, 3, 3, "t1");

    // Late cluster 3: nothing issues while arrival is partial.
    tick();
    drive(4'b0111, 64'h2000, 3, 3, 4);
    repeat (10) tick();
    chk("t2_no_issue", 64'(sys_valid), 64'd0);
    chk("t2_skew_err", 64'(skew_err), 64'd0);
    cl_valid = '1;
    tick();
    cl_valid = '0;
    sys_ready = 1'b1;
    #1 chk("t2_sys_valid", 64'(sys_valid), 64'd1);
    chk("t2_sys_addr", 64'(sys_addr), 64'h2000);
    tick();
    sys_ready = 1'b0; done = 1'b1;
    tick();
    done = 1'b0;

    // Cluster 2 disagrees on len; issued anyway with cluster 0's length.
    issue(64'h4000, 3, 3, 6, 7, 3, "t5");
    chk("t5_mismatch", 64'(mis_err), 64'd1);

    // Scaling boundaries: exactly 256 beats, zero beats, overflow.
    issue(64'h5000, 63, 5, 1, 63, 255, "b256");
    chk("b256_no_ovf", 64'(ovf_err), 64'd0);
    issue(64'h5100, 0, 0, 1, 0, 0, "b0");
    issue(64'h6000, 255, 7, 2, 255, 255, "ovf");
    chk("ovf_err", 64'(ovf_err), 64'd1);

    // In-flight limit of 2: third request waits for a completion.
    tick();
    drive('1, 64'h7000, 1, 2, 3);
    sys_ready = 1'b1;
    #1 chk("t4_cap1", 64'(cl_ready), 64'hF);
    tick(); chk("t4_out_a", 64'(outstanding), 64'd1);
    tick(); chk("t4_cap2", 64'(cl_ready), 64'hF);
    tick(); chk("t4_out_b", 64'(outstanding), 64'd2);
    tick(); chk("t4_blocked", 64'(cl_ready), 64'd0);
    tick(); chk("t4_no_valid", 64'(sys_valid), 64'd0);
    chk("t4_out_hold", 64'(outstanding), 64'd2);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_out_c", 64'(outstanding), 64'd1);
    chk("t4_cap3", 64'(cl_ready), 64'hF);
    tick(); chk("t4_out_d", 64'(outstanding), 64'd2);
    chk("t4_valid3", 64'(sys_valid), 64'd1);
    cl_valid = '0;
    tick();
    sys_ready = 1'b0;
    done = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    chk("t4_out_zero", 64'(outstanding), 64'd0);

    // Cluster 3 never arrives: skew error exactly at cycle 64.
    tick();
    drive(4'b0111, 64'h8000, 3, 3, 0);
    repeat (63) tick();
    chk("t3_skew_63", 64'(skew_err), 64'd0);
    tick();
    chk("t3_skew_64", 64'(skew_err), 64'd1);
    chk("t3_no_valid", 64'(sys_valid), 64'd0);
    cl_valid = '0;
    tick();

    // Backpressure holds the request stable; reset drops it at once.
    drive('1, 64'h9000, 15, 3, 9);
    tick();
    cl_valid = '0;
    #1 chk("t6_len", 64'(sys_len), 64'd15);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_hold_valid", 64'(sys_valid), 64'd1);
      chk("t6_hold_addr", 64'(sys_addr), 64'h9000);
      chk("t6_hold_len", 64'(sys_len), 64'd15);
      chk("t6_hold_id", 64'(sys_id), 64'd9);
    end
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(sys_valid), 64'd0);
    chk("t6_rst_addr", 64'(sys_addr), 64'd0);
    chk("t6_rst_len", 64'(sys_len), 64'd0);
    chk("t6_rst_id", 64'(sys_id), 64'd0);
    chk("t6_rst_outst", 64'(outstanding), 64'd0);
    chk("t6_rst_errs", 64'({mis_err, skew_err, ovf_err}), 64'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
